// File: rtl/mem_response_stage.sv
// mem_response_stage: EX->WB memory stage. Holds one instruction, tracks
// in-flight data requests, buffers early responses in an in-order FIFO,
// drops responses that belong to flushed loads, and aligns/extends load data.
module mem_response_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int TAG_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int OFF_W           = $clog2(DATA_WIDTH / 8)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_allow,
  input  logic                      in_is_load,
  input  logic [1:0]                in_size,
  input  logic                      in_unsigned,
  input  logic                      in_left,
  input  logic                      in_right,
  input  logic [OFF_W-1:0]          in_offset,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic                      in_reg_write,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  input  logic                      req_accepted,
  output logic                      req_allow,
  input  logic                      data_ok,
  input  logic [DATA_WIDTH-1:0]     data_rdata,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      wb_allow_in,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [DATA_WIDTH/8-1:0]   out_strobe,
  output logic                      out_reg_write,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      fwd_valid,
  output logic                      fwd_data_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Stage registers
  logic                  stage_valid_q, stage_valid_d;
  logic                  ld_q, uns_q, left_q, right_q, reg_write_q;
  logic [1:0]            size_q;
  logic [OFF_W-1:0]      off_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  // Request / response bookkeeping
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discard_q, discard_d;
  logic [DATA_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

  logic                  fifo_empty, resp_live, ready_go, fire_ld, push, pop;
  logic [CNT_W:0]        busy_sum;
  logic [DATA_WIDTH-1:0] src;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Handshake, response routing and counter next-state
  always_comb begin
    fifo_empty     = (fifo_cnt_q == '0);
    resp_live      = data_ok & (discard_q == '0);
    ready_go       = !ld_q | !fifo_empty | resp_live;
    out_valid      = stage_valid_q & ready_go;
    fwd_data_ready = out_valid;
    in_allow       = !stage_valid_q | (ready_go & wb_allow_in);
    fwd_valid      = stage_valid_q & reg_write_q;
    fire_ld        = out_valid & wb_allow_in & ld_q;
    pop            = fire_ld & !fifo_empty;
    // A live response bypasses the FIFO only when nothing is queued ahead of it
    // and the waiting load consumes it this cycle.
    push           = resp_live & !(fire_ld & fifo_empty) & !flush;
    src            = fifo_empty ? data_rdata : fifo_q[rd_ptr_q];
    busy_sum       = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    req_allow      = busy_sum < (CNT_W + 1)'(MAX_OUTSTANDING);

    outstanding_d  = outstanding_q + CNT_W'(req_accepted) - CNT_W'(data_ok);
    discard_d      = discard_q;
    if (flush)                          discard_d = outstanding_d;
    else if (data_ok && !resp_live)     discard_d = discard_q - 1'b1;

    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    fifo_cnt_d     = fifo_cnt_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    stage_valid_d = stage_valid_q;
    if (flush)         stage_valid_d = 1'b0;
    else if (in_allow) stage_valid_d = in_valid;
  end

  // Load data alignment, extension and write strobe
  logic [2:0]            lane3;
  logic [1:0]            k;
  logic [7:0]            b;
  logic [15:0]           h;
  logic [31:0]           w, lwl32, lwr32;
  logic [3:0]            lwl_s, lwr_s;
  logic [DATA_WIDTH-1:0] byte_ext, half_ext, word_ext, res;
  logic [BYTES-1:0]      strb;

  always_comb begin
    lane3    = 3'(off_q);
    k        = lane3[1:0];
    b        = 8'(src >> {lane3, 3'b000});
    h        = 16'(src >> {lane3[2:1], 4'b0000});
    w        = 32'(src >> {lane3[2], 5'b00000});
    byte_ext = uns_q ? DATA_WIDTH'(b) : DATA_WIDTH'($signed(b));
    half_ext = uns_q ? DATA_WIDTH'(h) : DATA_WIDTH'($signed(h));
    word_ext = uns_q ? DATA_WIDTH'(w) : DATA_WIDTH'($signed(w));
    lwl32    = w << {(2'd3 - k), 3'b000};
    lwr32    = w >> {k, 3'b000};
    lwl_s    = 4'b1111 << (2'd3 - k);
    lwr_s    = 4'b1111 >> k;
    res      = alu_q;
    strb     = '1;
    if (ld_q) begin
      if (left_q) begin
        res  = DATA_WIDTH'(lwl32);
        strb = BYTES'(lwl_s);
      end else if (right_q) begin
        res  = DATA_WIDTH'(lwr32);
        strb = BYTES'(lwr_s);
      end else begin
        case (size_q)
          2'd0:    res = byte_ext;
          2'd1:    res = half_ext;
          2'd2:    res = (DATA_WIDTH == 64) ? word_ext : src;
          default: res = src;
        endcase
      end
    end
    out_result    = res;
    out_strobe    = stage_valid_q ? strb : '0;
    out_reg_write = reg_write_q;
    out_tag       = tag_q;
  end

  // Stage valid and captured instruction fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      ld_q          <= 1'b0;
      uns_q         <= 1'b0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      size_q        <= '0;
      off_q         <= '0;
      alu_q         <= '0;
      tag_q         <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      if (in_valid && in_allow) begin
        ld_q        <= in_is_load;
        uns_q       <= in_unsigned;
        left_q      <= in_left;
        right_q     <= in_right;
        reg_write_q <= in_reg_write;
        size_q      <= in_size;
        off_q       <= in_offset;
        alu_q       <= in_alu_result;
        tag_q       <= in_tag;
      end
    end
  end

  // In-flight and discard counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Response FIFO pointers, occupancy and storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) fifo_q[wr_ptr_q] <= data_rdata;
    end
  end

endmodule

// File: tb/tb_mem_response_stage.sv
// Bench for mem_response_stage: 32-bit instance checked every cycle against a
// queue-based model plus directed literals; 64-bit instance checked directly.
module tb_mem_response_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // 32-bit instance signals
  logic        in_valid, in_allow, in_is_load, in_unsigned, in_left, in_right;
  logic [1:0]  in_size, in_offset;
  logic [31:0] in_alu_result, data_rdata, out_result;
  logic        in_reg_write, req_accepted, req_allow, data_ok, flush;
  logic        out_valid, wb_allow_in, out_reg_write, fwd_valid, fwd_data_ready;
  logic [15:0] in_tag, out_tag;
  logic [3:0]  out_strobe;

  // 64-bit instance signals
  logic        w_in_valid, w_in_allow, w_in_is_load, w_in_unsigned, w_in_left, w_in_right;
  logic [1:0]  w_in_size;
  logic [2:0]  w_in_offset;
  logic [63:0] w_in_alu_result, w_data_rdata, w_out_result;
  logic        w_in_reg_write, w_req_accepted, w_req_allow, w_data_ok, w_flush;
  logic        w_out_valid, w_wb_allow_in, w_out_reg_write, w_fwd_valid, w_fwd_data_ready;
  logic [15:0] w_in_tag, w_out_tag;
  logic [7:0]  w_out_strobe;

  mem_response_stage #(.DATA_WIDTH(32), .TAG_WIDTH(16), .MAX_OUTSTANDING(2)) dut32 (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_allow(in_allow),
    .in_is_load(in_is_load), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_left(in_left), .in_right(in_right), .in_offset(in_offset),
    .in_alu_result(in_alu_result), .in_reg_write(in_reg_write), .in_tag(in_tag),
    .req_accepted(req_accepted), .req_allow(req_allow), .data_ok(data_ok),
    .data_rdata(data_rdata), .flush(flush), .out_valid(out_valid),
    .wb_allow_in(wb_allow_in), .out_result(out_result), .out_strobe(out_strobe),
    .out_reg_write(out_reg_write), .out_tag(out_tag), .fwd_valid(fwd_valid),
    .fwd_data_ready(fwd_data_ready)
  );

  mem_response_stage #(.DATA_WIDTH(64), .TAG_WIDTH(16), .MAX_OUTSTANDING(2)) dut64 (
    .clock(clk), .reset(rst), .in_valid(w_in_valid), .in_allow(w_in_allow),
    .in_is_load(w_in_is_load), .in_size(w_in_size), .in_unsigned(w_in_unsigned),
    .in_left(w_in_left), .in_right(w_in_right), .in_offset(w_in_offset),
    .in_alu_result(w_in_alu_result), .in_reg_write(w_in_reg_write), .in_tag(w_in_tag),
    .req_accepted(w_req_accepted), .req_allow(w_req_allow), .data_ok(w_data_ok),
    .data_rdata(w_data_rdata), .flush(w_flush), .out_valid(w_out_valid),
    .wb_allow_in(w_wb_allow_in), .out_result(w_out_result), .out_strobe(w_out_strobe),
    .out_reg_write(w_out_reg_write), .out_tag(w_out_tag), .fwd_valid(w_fwd_valid),
    .fwd_data_ready(w_fwd_data_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model (32-bit instance) ----------------
  typedef struct packed {
    logic        ld;
    logic [1:0]  size;
    logic        uns, left, right;
    logic [1:0]  off;
    logic [31:0] alu;
    logic        rw;
    logic [15:0] tag;
  } ins_t;

  bit          m_sv;
  ins_t        m_st;
  bit          m_inflight[$];   // one entry per issued request, 1 = killed by flush
  logic [31:0] m_buf[$];        // responses returned but not yet consumed

  logic [3:0] lwl_tab [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
  logic [3:0] lwr_tab [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};

  function automatic bit head_live();
    return (m_inflight.size() > 0) && !m_inflight[0];
  endfunction

  function automatic void model_align(input ins_t s, input logic [31:0] d,
                                      output logic [31:0] r, output logic [3:0] st);
    logic [31:0] v;
    st = 4'hF;
    if (!s.ld) v = s.alu;
    else if (s.left) begin
      v  = d << (8 * (3 - s.off));
      st = lwl_tab[s.off];
    end else if (s.right) begin
      v  = d >> (8 * s.off);
      st = lwr_tab[s.off];
    end else if (s.size == 2'd0) begin
      v = (d >> (8 * s.off)) & 32'h0000_00FF;
      if (!s.uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (s.size == 2'd1) begin
      v = (d >> (16 * (s.off / 2))) & 32'h0000_FFFF;
      if (!s.uns && v[15]) v = v | 32'hFFFF_0000;
    end else v = d;
    r = v;
  endfunction

  // Model state advance on each clock edge
  always @(posedge clk or posedge rst) begin : model_upd
    bit rdy, fire, empty0, live, acc;
    int n;
    if (rst) begin
      m_sv <= 1'b0;
      m_st <= '0;
      m_inflight.delete();
      m_buf.delete();
    end else begin
      empty0 = (m_buf.size() == 0);
      rdy    = !m_st.ld || !empty0 || (data_ok && head_live());
      fire   = m_sv && m_st.ld && rdy && wb_allow_in;
      acc    = !m_sv || (rdy && wb_allow_in);
      live   = 1'b0;
      if (data_ok && m_inflight.size() > 0) live = !m_inflight.pop_front();
      if (req_accepted) m_inflight.push_back(1'b0);
      if (flush) begin
        n = m_inflight.size();
        m_inflight.delete();
        repeat (n) m_inflight.push_back(1'b1);
        m_buf.delete();
        m_sv <= 1'b0;
      end else begin
        if (fire && !empty0) void'(m_buf.pop_front());
        if (live && !(fire && empty0)) m_buf.push_back(data_rdata);
        if (acc) m_sv <= in_valid;
      end
      if (acc && in_valid)
        m_st <= '{in_is_load, in_size, in_unsigned, in_left, in_right, in_offset,
                  in_alu_result, in_reg_write, in_tag};
    end
  end

  // Compare process: outputs against the model every cycle, mid-cycle
  always @(negedge clk) begin : compare
    bit e_rdy, e_ov;
    logic [31:0] e_src, e_res;
    logic [3:0]  e_st;
    if (!rst && chk_en) begin
      e_rdy = !m_st.ld || (m_buf.size() > 0) || (data_ok && head_live());
      e_ov  = m_sv && e_rdy;
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("fwd_data_ready", 64'(fwd_data_ready), 64'(e_ov));
      chk("in_allow", 64'(in_allow), 64'(!m_sv || (e_rdy && wb_allow_in)));
      chk("req_allow", 64'(req_allow), 64'((m_inflight.size() + m_buf.size()) < 2));
      chk("fwd_valid", 64'(fwd_valid), 64'(m_sv && m_st.rw));
      if (m_sv) begin
        chk("out_tag", 64'(out_tag), 64'(m_st.tag));
        chk("out_reg_write", 64'(out_reg_write), 64'(m_st.rw));
      end
      if (e_ov) begin
        e_src = (m_buf.size() > 0) ? m_buf[0] : data_rdata;
        model_align(m_st, e_src, e_res, e_st);
        chk("out_result", 64'(out_result), 64'(e_res));
        chk("out_strobe", 64'(out_strobe), 64'(e_st));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] tag_ctr = 16'hA000;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_is_load = 0; in_size = 0; in_unsigned = 0; in_left = 0;
    in_right = 0; in_offset = 0; in_alu_result = 0; in_reg_write = 0; in_tag = 0;
    req_accepted = 0; data_ok = 0; data_rdata = 0; flush = 0; wb_allow_in = 1;
  endtask

  task automatic idle64();
    w_in_valid = 0; w_in_is_load = 0; w_in_size = 0; w_in_unsigned = 0; w_in_left = 0;
    w_in_right = 0; w_in_offset = 0; w_in_alu_result = 0; w_in_reg_write = 0; w_in_tag = 0;
    w_req_accepted = 0; w_data_ok = 0; w_data_rdata = 0; w_flush = 0; w_wb_allow_in = 1;
  endtask

  task automatic present_load(input logic [1:0] sz, input logic u, input logic l,
                              input logic r, input logic [1:0] off);
    in_valid = 1; in_is_load = 1; in_size = sz; in_unsigned = u; in_left = l;
    in_right = r; in_offset = off; in_reg_write = 1; in_tag = tag_ctr;
    in_alu_result = 32'h0BAD_0BAD;
    tag_ctr++;
  endtask

  // Request accepted as the load enters; response in the following cycle.
  task automatic load32(input string nm, input logic [1:0] sz, input logic u,
                        input logic l, input logic r, input logic [1:0] off,
                        input logic [31:0] d, input logic [31:0] er, input logic [3:0] es);
    idle(); present_load(sz, u, l, r, off); req_accepted = 1;
    cyc();
    idle(); data_ok = 1; data_rdata = d;
    #2;
    chk({nm, ".valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".result"}, 64'(out_result), 64'(er));
    chk({nm, ".strobe"}, 64'(out_strobe), 64'(es));
    cyc();
    idle();
  endtask

  task automatic load64(input string nm, input logic [1:0] sz, input logic u,
                        input logic l, input logic r, input logic [2:0] off,
                        input logic [63:0] d, input logic [63:0] er, input logic [7:0] es);
    idle64();
    w_in_valid = 1; w_in_is_load = 1; w_in_size = sz; w_in_unsigned = u; w_in_left = l;
    w_in_right = r; w_in_offset = off; w_in_reg_write = 1; w_in_tag = 16'h6464;
    w_req_accepted = 1;
    cyc();
    idle64(); w_data_ok = 1; w_data_rdata = d;
    #2;
    chk({nm, ".valid"}, 64'(w_out_valid), 64'd1);
    chk({nm, ".result"}, w_out_result, er);
    chk({nm, ".strobe"}, 64'(w_out_strobe), 64'(es));
    cyc();
    idle64();
  endtask

  initial begin
    rst = 1;
    idle(); idle64();
    #12;
    chk("rst.in_allow", 64'(in_allow), 64'd1);
    chk("rst.req_allow", 64'(req_allow), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_result", 64'(out_result), 64'd0);
    chk("rst.out_strobe", 64'(out_strobe), 64'd0);
    chk("rst.fwd", 64'({fwd_valid, fwd_data_ready}), 64'd0);
    chk("rst64.out_strobe", 64'(w_out_strobe), 64'd0);
    chk("rst64.in_allow", 64'(w_in_allow), 64'd1);
    @(posedge clk); #1;
    rst = 0;
    chk_en = 1;
    cyc();

    // Alignment and extension, 32-bit
    load32("lb3",  2'd0, 0, 0, 0, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80, 4'hF);
    load32("lbu3", 2'd0, 1, 0, 0, 2'd3, 32'h80FF_1234, 32'h0000_0080, 4'hF);
    load32("lh2",  2'd1, 0, 0, 0, 2'd2, 32'h80FF_1234, 32'hFFFF_80FF, 4'hF);
    load32("lhu1", 2'd1, 1, 0, 0, 2'd1, 32'h80FF_1234, 32'h0000_1234, 4'hF);
    load32("lw",   2'd2, 0, 0, 0, 2'd0, 32'h80FF_1234, 32'h80FF_1234, 4'hF);
    load32("lwl1", 2'd2, 0, 1, 0, 2'd1, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100);
    load32("lwl0", 2'd2, 0, 1, 0, 2'd0, 32'hAABB_CCDD, 32'hDD00_0000, 4'b1000);
    load32("lwr2", 2'd2, 0, 0, 1, 2'd2, 32'hAABB_CCDD, 32'h0000_AABB, 4'b0011);
    load32("lwr3", 2'd2, 0, 0, 1, 2'd3, 32'hAABB_CCDD, 32'h0000_00AA, 4'b0001);

    // Non-load passes the ALU result
    idle(); in_valid = 1; in_alu_result = 32'hDEAD_BEEF; in_reg_write = 1; in_tag = 16'h0101;
    cyc();
    idle(); #2;
    chk("alu.valid", 64'(out_valid), 64'd1);
    chk("alu.result", 64'(out_result), 64'hDEAD_BEEF);
    chk("alu.fwd_valid", 64'(fwd_valid), 64'd1);
    cyc();

    // Response buffered while the load waits in EX behind a stalled instruction
    idle(); in_valid = 1; in_alu_result = 32'h55; req_accepted = 1;
    cyc();
    idle(); wb_allow_in = 0; present_load(2'd2, 0, 0, 0, 2'd0); req_accepted = 1;
    cyc();
    idle(); wb_allow_in = 0; present_load(2'd2, 0, 0, 0, 2'd0);
    data_ok = 1; data_rdata = 32'h1122_3344;
    #2; chk("buf.req_allow_full", 64'(req_allow), 64'd0);
    cyc();
    idle(); present_load(2'd2, 0, 0, 0, 2'd0);
    #2; chk("buf.req_allow_fifo", 64'(req_allow), 64'd0);
    chk("buf.in_allow", 64'(in_allow), 64'd1);
    cyc();
    idle(); present_load(2'd0, 1, 0, 0, 2'd1);
    #2; chk("buf.fire_valid", 64'(out_valid), 64'd1);
    chk("buf.fire_result", 64'(out_result), 64'h1122_3344);
    cyc();
    idle(); data_ok = 1; data_rdata = 32'h0000_9A00;
    #2; chk("buf.second", 64'(out_result), 64'h0000_009A);
    cyc();
    idle(); cyc();

    // Flush with two loads in flight: both responses dropped
    idle(); present_load(2'd2, 0, 0, 0, 2'd0); req_accepted = 1;
    cyc();
    idle(); present_load(2'd2, 0, 0, 0, 2'd0); req_accepted = 1;
    cyc();
    idle(); flush = 1;
    cyc();
    idle(); present_load(2'd2, 0, 0, 0, 2'd0); data_ok = 1; data_rdata = 32'h1111_1111;
    #2; chk("fl.drop1_valid", 64'(out_valid), 64'd0);
    cyc();
    idle(); req_accepted = 1; data_ok = 1; data_rdata = 32'h2222_2222;
    #2; chk("fl.drop2_valid", 64'(out_valid), 64'd0);
    cyc();
    idle(); data_ok = 1; data_rdata = 32'h3333_3333;
    #2; chk("fl.third_valid", 64'(out_valid), 64'd1);
    chk("fl.third_result", 64'(out_result), 64'h3333_3333);
    cyc();
    idle(); cyc();

    // Reset mid-stall with one request outstanding
    idle(); present_load(2'd2, 0, 0, 0, 2'd0); req_accepted = 1;
    cyc();
    idle(); #2;
    chk("stall.valid", 64'(out_valid), 64'd0);
    rst = 1; #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.in_allow", 64'(in_allow), 64'd1);
    chk("mrst.req_allow", 64'(req_allow), 64'd1);
    chk("mrst.out_result", 64'(out_result), 64'd0);
    chk("mrst.out_strobe", 64'(out_strobe), 64'd0);
    chk("mrst.out_tag", 64'(out_tag), 64'd0);
    chk("mrst.fwd", 64'({fwd_valid, fwd_data_ready}), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    cyc();

    // 64-bit instance
    load64("w.lw4",  2'd2, 0, 0, 0, 3'd4, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001, 8'hFF);
    load64("w.ld",   2'd3, 0, 0, 0, 3'd0, 64'h8000_0001_1234_5678, 64'h8000_0001_1234_5678, 8'hFF);
    load64("w.lbu7", 2'd0, 1, 0, 0, 3'd7, 64'h8000_0001_1234_5678, 64'h0000_0000_0000_0080, 8'hFF);
    load64("w.lh6",  2'd1, 0, 0, 0, 3'd6, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_FFFF_8000, 8'hFF);
    load64("w.lwr5", 2'd2, 0, 0, 1, 3'd5, 64'h8000_0001_1234_5678, 64'h0000_0000_0080_0000, 8'h07);
    load64("w.lwl1", 2'd2, 0, 1, 0, 3'd1, 64'h8000_0001_AABB_CCDD, 64'h0000_0000_CCDD_0000, 8'h0C);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_response_stage.md
Name: mem_response_stage

Overview:
- Parametrised successor to the fixed-latency memory/writeback-prep stage. Sits between EX and WB in the cpu_core pipeline.
- Accepts instructions from EX and absorbs variable-latency data-bus responses in order through a response FIFO.
- Drops responses belonging to flushed loads, and aligns and extends load data for DATA_WIDTH 32 or 64.
- Produces the WB payload, the register write strobe and the ID forwarding signals.

Parameters:
DATA_WIDTH, 32, datapath width; legal values 32 or 64; BYTES = DATA_WIDTH/8
TAG_WIDTH, 16, opaque per-instruction payload (dest register, cp0 fields, exception info) carried to WB
MAX_OUTSTANDING, 2, max data requests in flight plus buffered responses; power of 2, at least 1
OFF_W, log2(BYTES), byte-offset width (derived)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
in_valid  in  1  EX instruction valid
in_allow  out  1  stage can accept (allow_in)
in_is_load  in  1  instruction expects a memory response
in_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_WIDTH=64)
in_unsigned  in  1  zero-extend instead of sign-extend
in_left  in  1  LWL
in_right  in  1  LWR
in_offset  in  OFF_W  address low bits
in_alu_result  in  DATA_WIDTH  result for non-loads
in_reg_write  in  1  writes the register file
in_tag  in  TAG_WIDTH  pass-through payload
req_accepted  in  1  EX request handshake (req & addr_ok) this cycle
req_allow  out  1  EX may issue a new data request
data_ok  in  1  response beat valid
data_rdata  in  DATA_WIDTH  response data
flush  in  1  WB exception or eret flush
out_valid  out  1  valid to WB
wb_allow_in  in  1  WB can accept
out_result  out  DATA_WIDTH  aligned result
out_strobe  out  BYTES  register write byte strobe
out_reg_write  out  1  registered in_reg_write
out_tag  out  TAG_WIDTH  registered in_tag
fwd_valid  out  1  stage valid & reg_write (ID stall/forward check)
fwd_data_ready  out  1  out_result is valid this cycle

Behaviour:
- Async reset clears all state:
  - stage_valid=0, outstanding=0, discard=0, FIFO empty.
  - in_allow=1, req_allow=1, out_valid=0, fwd_*=0.
  - Stored fields =0, so out_result=0 and out_strobe=0.
- outstanding (width log2(MAX_OUTSTANDING)+1):
  - +1 on req_accepted; −1 on data_ok; both in one cycle → unchanged.
- req_allow = (outstanding + fifo_count) < MAX_OUTSTANDING. This guarantees the FIFO never overflows.
- Response routing on data_ok:
  - If discard>0: discard −1 and the data is dropped.
  - Else: push to FIFO, or bypass when the FIFO is empty and the current load consumes this cycle.
- ready_go:
  - Non-load: 1.
  - Load: FIFO non-empty, or (data_ok & discard==0).
- in_allow = !stage_valid | (ready_go & wb_allow_in). out_valid = stage_valid & ready_go. fwd_data_ready = out_valid.
- Data source: FIFO head has priority over bypass. The FIFO head is popped when a load fires (out_valid & wb_allow_in).
- Stage capture: stage_valid <= in_valid when in_allow. Fields are captured on in_valid & in_allow.
- flush (highest priority, single cycle):
  - stage_valid<=0 and FIFO cleared.
  - discard <= outstanding_next − (data_ok ? 0 : 0). This equals all in-flight requests, including one accepted in the flush cycle; a data_ok in the flush cycle is dropped.
  - in_allow is not forced low.
- Alignment, with lane = in_offset and data d:
  - byte: d[8·lane+:8], extended.
  - half: lane[0] ignored, d[16·(lane>>1)+:16], extended.
  - word (64-bit only): d[32·lane[2]+:32], extended.
  - dword: d.
  - Extension: sign-extend unless in_unsigned.
  - Strobe: all ones for byte, half, word and dword.
- LWL/LWR operate on the 32-bit word w selected by lane[2] (64-bit), with k = lane[1:0].
  - LWL result: w << 8·(3−k). Strobe low-nibble patterns: 1000, 1100, 1110, 1111 for k=0..3.
  - LWR result: w >> 8·k. Strobe: 1111, 0111, 0011, 0001.
  - When DATA_WIDTH=64, upper 32 result bits and upper 4 strobe bits are 0.
- Non-load: out_result = in_alu_result, strobe all ones.
- Load stall: a load waits indefinitely for its response, with no timeout.
- fwd_valid = stage_valid & out_reg_write.

Test Plan:
- DATA_WIDTH=32, lb at offset 3, data_ok same cycle with rdata 0x80FF_1234 → out_result 0xFFFF_FF80, strobe 1111, out_valid in the response cycle; lbu → 0x0000_0080.
- LWL k=1, rdata 0xAABB_CCDD → 0xCCDD_0000, strobe 1100. LWR k=2 → 0x0000_AABB, strobe 0011.
- Response arrives while the load is still in EX because wb_allow_in=0 → data buffered in the FIFO, req_allow=0 at MAX_OUTSTANDING=2 with 2 pending, load fires immediately on entry with the buffered data.
- Two loads in flight, flush asserted → stage cleared, discard=2, next two data_ok dropped. A third load issued afterwards receives the third response.
- DATA_WIDTH=64, lw offset 4, rdata 0x8000_0001_1234_5678 → 0xFFFF_FFFF_8000_0001; ld → full data.
- Reset asserted mid-stall with outstanding=1 → all outputs 0 immediately, in_allow=1, req_allow=1.
